// File: rtl/sipo.sv
// Serial-in, parallel-out word assembler.
// Collects N = OUTPUT_SIZE/INPUT_SIZE serial words MSB-first into one parallel
// word and hands it to a downstream FIFO write port. One completed group can
// wait in the output register while the next group is being accumulated, so
// only the last word of a group ever has to stall on a full FIFO.
module sipo #(
    parameter int INPUT_SIZE  = 64,
    parameter int OUTPUT_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [INPUT_SIZE-1:0]  i_serial,
    input  logic                   i_valid,
    output logic                   i_ready,
    output logic [OUTPUT_SIZE-1:0] o_parallel,
    input  logic                   fifo_full,
    output logic                   fifo_we,
    output logic                   o_overflow
);

    localparam int N      = OUTPUT_SIZE / INPUT_SIZE;
    localparam int ACC_W  = OUTPUT_SIZE - INPUT_SIZE;
    localparam int CNT_W  = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Architectural state
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [OUTPUT_SIZE-1:0] out_q, out_d;
    logic                   pend_q, pend_d;
    logic                   ovf_q, ovf_d;

    // Combinational helpers
    logic                   fifo_we_s;
    logic                   last_s;
    logic                   stall_s;
    logic                   i_ready_s;
    logic                   accept_s;
    logic [OUTPUT_SIZE-1:0] shift_s;

    // The new word always enters at the bottom; older words move up, so the
    // first word of a group ends up in the most significant slot.
    assign shift_s   = {acc_q, i_serial};

    assign last_s    = (cnt_q == CNT_LAST);
    assign fifo_we_s = pend_q & ~fifo_full & ce;
    // Only the completing word stalls, and only if the waiting group cannot
    // leave on this same edge. Held low while reset is asserted.
    assign stall_s   = last_s & pend_q & ~fifo_we_s;
    assign i_ready_s = rst & ce & ~stall_s;
    assign accept_s  = i_valid & i_ready_s;

    assign i_ready    = i_ready_s;
    assign fifo_we    = fifo_we_s;
    assign o_parallel = out_q;
    assign o_overflow = ovf_q;

    // Next-state: accumulation, group completion, pending handshake, overflow.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        out_d  = out_q;
        pend_d = pend_q;
        ovf_d  = ovf_q;

        if (accept_s) begin
            if (last_s) begin
                out_d = shift_s;
                cnt_d = CNT_ZERO;
            end else begin
                acc_d = shift_s[ACC_W-1:0];
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end

        // A completion on the same edge as a write replaces the group that is
        // leaving, so pending stays set.
        if (accept_s && last_s) begin
            pend_d = 1'b1;
        end else if (fifo_we_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        if (ce && i_valid && !i_ready_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= CNT_ZERO;
            acc_q  <= {ACC_W{1'b0}};
            out_q  <= {OUTPUT_SIZE{1'b0}};
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sipo.sv
// Directed testbench for sipo with default parameters (4 x 64-bit words).
module tb_sipo;

    logic         clk;
    logic         rst;
    logic         ce;
    logic [63:0]  i_serial;
    logic         i_valid;
    logic         i_ready;
    logic [255:0] o_parallel;
    logic         fifo_full;
    logic         fifo_we;
    logic         o_overflow;

    int vectors;
    int miscompares;
    int cyc;

    logic [255:0] wr_q[$];
    int           wr_cyc[$];

    sipo #(.INPUT_SIZE(64), .OUTPUT_SIZE(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .i_serial   (i_serial),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .o_parallel (o_parallel),
        .fifo_full  (fifo_full),
        .fifo_we    (fifo_we),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: capture o_parallel on every edge where fifo_we is high.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_we === 1'b1) begin
            wr_q.push_back(o_parallel);
            wr_cyc.push_back(cyc);
        end
    end

    function automatic logic [255:0] grp(input int a, input int b, input int c, input int d);
        return {64'(a), 64'(b), 64'(c), 64'(d)};
    endfunction

    task automatic check_vec(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input logic [255:0] exp[$]);
        check_vec({tag, "_count"}, 256'(wr_q.size()), 256'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < wr_q.size()) begin
                check_vec($sformatf("%s_w%0d", tag, i), wr_q[i], exp[i]);
            end else begin
                check_vec($sformatf("%s_w%0d_missing", tag, i), 256'(0), exp[i]);
            end
        end
    endtask

    initial begin
        logic [255:0] exp_q[$];
        int           nw;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst         = 1'b0;
        ce          = 1'b1;
        i_valid     = 1'b0;
        i_serial    = 64'd0;
        fifo_full   = 1'b0;

        // ---- reset state ----
        #2;
        check_vec("rst_parallel", o_parallel, 256'd0);
        check_vec("rst_we",       256'(fifo_we),    256'd0);
        check_vec("rst_ready",    256'(i_ready),    256'd0);
        check_vec("rst_overflow", 256'(o_overflow), 256'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ---- basic assembly ----
        for (int w = 0; w < 4; w++) begin
            i_valid  = 1'b1;
            i_serial = 64'(w);
            #1;
            check_vec($sformatf("basic_ready%0d", w), 256'(i_ready), 256'd1);
            next_cycle();
        end
        i_valid = 1'b0;
        #1;
        check_vec("basic_we_hi", 256'(fifo_we), 256'd1);
        check_vec("basic_data",  o_parallel, grp(0, 1, 2, 3));
        next_cycle();
        check_vec("basic_we_lo", 256'(fifo_we), 256'd0);
        exp_q = '{grp(0, 1, 2, 3)};
        check_writes("basic", exp_q);
        wr_q.delete();
        wr_cyc.delete();

        // ---- streaming ----
        for (int w = 0; w < 16; w++) begin
            i_valid  = 1'b1;
            i_serial = 64'(w);
            #1;
            check_vec($sformatf("stream_ready%0d", w), 256'(i_ready), 256'd1);
            next_cycle();
        end
        i_valid = 1'b0;
        repeat (2) next_cycle();
        exp_q = '{grp(0, 1, 2, 3), grp(4, 5, 6, 7), grp(8, 9, 10, 11), grp(12, 13, 14, 15)};
        check_writes("stream", exp_q);
        for (int i = 1; i < wr_cyc.size(); i++) begin
            check_vec($sformatf("stream_gap%0d", i), 256'(wr_cyc[i] - wr_cyc[i-1]), 256'd4);
        end
        check_vec("stream_overflow", 256'(o_overflow), 256'd0);
        wr_q.delete();
        wr_cyc.delete();

        // ---- backpressure (offer only when a word is expected to be taken) ----
        nw = 0;
        for (int k = 0; k < 18; k++) begin
            fifo_full = (k >= 3 && k < 14) ? 1'b1 : 1'b0;
            if ((k <= 6 || k >= 14) && nw < 8) begin
                i_valid  = 1'b1;
                i_serial = 64'(nw);
                nw       = nw + 1;
            end else begin
                i_valid  = 1'b0;
            end
            #1;
            if (k == 4) check_vec("bp_ready_w4",  256'(i_ready), 256'd1);
            if (k == 6) check_vec("bp_ready_w6",  256'(i_ready), 256'd1);
            if (k == 7) check_vec("bp_stall_beg", 256'(i_ready), 256'd0);
            if (k == 13) check_vec("bp_stall_end", 256'(i_ready), 256'd0);
            if (k == 10) begin
                check_vec("bp_hold_data", o_parallel, grp(0, 1, 2, 3));
                check_vec("bp_hold_we",   256'(fifo_we), 256'd0);
            end
            if (k == 14) begin
                check_vec("bp_release_we",    256'(fifo_we), 256'd1);
                check_vec("bp_release_ready", 256'(i_ready), 256'd1);
            end
            next_cycle();
        end
        i_valid   = 1'b0;
        fifo_full = 1'b0;
        exp_q = '{grp(0, 1, 2, 3), grp(4, 5, 6, 7)};
        check_writes("bp", exp_q);
        check_vec("bp_overflow", 256'(o_overflow), 256'd0);
        wr_q.delete();
        wr_cyc.delete();

        // ---- overflow: keep offering while stalled, with distinct dropped values ----
        nw = 16;
        for (int k = 0; k < 18; k++) begin
            fifo_full = (k >= 3 && k < 14) ? 1'b1 : 1'b0;
            i_valid   = (nw < 24) ? 1'b1 : 1'b0;
            if (k >= 7 && k < 14) begin
                i_serial = 64'(100 + k);
            end else begin
                i_serial = 64'(nw);
                if (nw < 24) nw = nw + 1;
            end
            #1;
            if (k == 8)  check_vec("ovf_set",  256'(o_overflow), 256'd1);
            if (k == 12) check_vec("ovf_hold_data", o_parallel, grp(16, 17, 18, 19));
            next_cycle();
        end
        i_valid   = 1'b0;
        fifo_full = 1'b0;
        exp_q = '{grp(16, 17, 18, 19), grp(20, 21, 22, 23)};
        check_writes("ovf", exp_q);
        repeat (3) next_cycle();
        check_vec("ovf_sticky", 256'(o_overflow), 256'd1);
        wr_q.delete();
        wr_cyc.delete();

        // ---- reset mid-group with a pending group ----
        fifo_full = 1'b1;
        for (int w = 24; w < 30; w++) begin
            i_valid  = 1'b1;
            i_serial = 64'(w);
            next_cycle();
        end
        i_valid = 1'b0;
        #1;
        check_vec("prerst_data", o_parallel, grp(24, 25, 26, 27));
        #2;
        rst = 1'b0;
        #1;
        check_vec("midrst_data",     o_parallel, 256'd0);
        check_vec("midrst_we",       256'(fifo_we),    256'd0);
        check_vec("midrst_ready",    256'(i_ready),    256'd0);
        check_vec("midrst_overflow", 256'(o_overflow), 256'd0);
        fifo_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int w = 8; w < 12; w++) begin
            i_valid  = 1'b1;
            i_serial = 64'(w);
            #1;
            if (w == 8) check_vec("postrst_ready", 256'(i_ready), 256'd1);
            next_cycle();
        end
        i_valid = 1'b0;
        repeat (3) next_cycle();
        exp_q = '{grp(8, 9, 10, 11)};
        check_writes("rst", exp_q);
        wr_q.delete();
        wr_cyc.delete();

        // ---- clock enable ----
        for (int w = 40; w < 42; w++) begin
            i_valid  = 1'b1;
            i_serial = 64'(w);
            next_cycle();
        end
        ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_valid  = 1'b1;
            i_serial = 64'(99);
            #1;
            check_vec($sformatf("ce_ready%0d", k), 256'(i_ready), 256'd0);
            check_vec($sformatf("ce_we%0d", k),    256'(fifo_we), 256'd0);
            next_cycle();
        end
        ce = 1'b1;
        for (int w = 42; w < 44; w++) begin
            i_valid  = 1'b1;
            i_serial = 64'(w);
            next_cycle();
        end
        i_valid = 1'b0;
        ce      = 1'b0;
        #1;
        check_vec("ce_pend_data", o_parallel, grp(40, 41, 42, 43));
        check_vec("ce_pend_we",   256'(fifo_we), 256'd0);
        repeat (2) next_cycle();
        check_vec("ce_frozen_we", 256'(fifo_we), 256'd0);
        ce = 1'b1;
        #1;
        check_vec("ce_resume_we", 256'(fifo_we), 256'd1);
        repeat (2) next_cycle();
        exp_q = '{grp(40, 41, 42, 43)};
        check_writes("ce", exp_q);
        check_vec("ce_overflow", 256'(o_overflow), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sipo.md
SIPO -- requirements
Module: sipo

Interface
REQ-001 Parameter INPUT_SIZE, default 64, width of one serial input word.
REQ-002 Parameter OUTPUT_SIZE, default 256, width of the assembled parallel word; SHALL be an integer multiple N = OUTPUT_SIZE/INPUT_SIZE of INPUT_SIZE, with N >= 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ce  input  1  clock enable; 0 freezes all state.
REQ-006 i_serial  input  INPUT_SIZE  serial input word.
REQ-007 i_valid  input  1  i_serial holds a word.
REQ-008 i_ready  output  1  block can accept a word this cycle.
REQ-009 o_parallel  output  OUTPUT_SIZE  assembled word presented to the downstream FIFO write port.
REQ-010 fifo_full  input  1  downstream FIFO full.
REQ-011 fifo_we  output  1  downstream FIFO write enable; FIFO captures o_parallel on a rising edge where fifo_we=1.
REQ-012 o_overflow  output  1  sticky flag: a word was offered while i_ready=0.

Function
REQ-013 Accept a word on a rising edge where ce=1, i_valid=1 and i_ready=1.
REQ-014 Input ordering: the first accepted word of a group SHALL occupy o_parallel[OUTPUT_SIZE-1 -: INPUT_SIZE]; the Nth word SHALL occupy [INPUT_SIZE-1:0]. This is MSB-first, the inverse of the team's piso.
REQ-015 Keep an accumulation register and a word counter, 0..N-1; each accepted word increments the counter.
REQ-016 Keep an output register driving o_parallel, plus a pending flag.
REQ-017 On acceptance of the Nth word, on the same edge: load {accumulated words, i_serial} into the output register; set pending=1; reset the counter to 0.
REQ-018 fifo_we SHALL be combinational: fifo_we = pending & ~fifo_full & ce.
REQ-019 On an edge with fifo_we=1, pending SHALL clear, unless REQ-020 applies.
REQ-020 Simultaneous write and Nth-word completion: the output register reloads with the new group and pending stays 1. No word is lost and no word is duplicated.
REQ-021 i_ready = ce & ~(counter==N-1 & pending & ~fifo_we).
- Words 1..N-1 of the next group are always accepted while a previous group waits.
- The Nth word stalls only while the FIFO cannot take the pending group.
REQ-022 Latency: fifo_we is asserted in the cycle immediately after the edge that accepted the Nth word, provided fifo_full=0 and ce=1.
REQ-023 Throughput: with fifo_full=0, sustained i_valid=1 SHALL produce one FIFO write every N cycles with i_ready held at 1.
REQ-024 fifo_full=1 while pending: hold o_parallel stable and fifo_we=0 until fifo_full falls.
REQ-025 ce=0: hold counter, accumulation register, output register, pending and o_overflow; fifo_we=0; i_ready=0.
REQ-026 When ce=1, i_valid=1 and i_ready=0: drop the word, leave the counter unchanged, and set o_overflow=1. The flag clears only on reset.
REQ-027 o_parallel SHALL only change on edges that load a completed group.

Reset
REQ-028 While rst=0, immediately and independently of clk, the block SHALL clear:
- counter
- pending
- o_overflow
- accumulation register
- output register
REQ-029 Resulting output values during reset: o_parallel=0, fifo_we=0, i_ready=0 (ce gating is not consulted while held in reset).
REQ-030 Reset asserted mid-group or with a pending word SHALL discard all partial and pending data; no fifo_we pulse SHALL follow.
REQ-031 The first edge after rst returns to 1 SHALL be able to accept a word.

Verification
REQ-032 Basic assembly. Stimulus: defaults; fifo_full=0; words 0,1,2,3 on consecutive cycles. Required: o_parallel={64'd0,64'd1,64'd2,64'd3}; fifo_we high exactly one cycle, the cycle after word 3; i_ready stays 1.
REQ-033 Streaming. Stimulus: continuous words 0..15. Required: four writes, one every 4 cycles, with values {0,1,2,3}, {4,5,6,7}, {8,9,10,11}, {12,13,14,15}; o_overflow=0.
REQ-034 Backpressure. Stimulus: fifo_full=1 for 10 cycles after the first group; continuous input. Required:
- words 4,5,6 accepted;
- i_ready=0 with counter at 3;
- o_parallel holds {0,1,2,3};
- after fifo_full falls, {0,1,2,3} is written, then word 7 is accepted and {4,5,6,7} is written.
REQ-035 Overflow. Stimulus: as REQ-034 but keep i_valid=1 while i_ready=0. Required: o_overflow=1 and held; dropped words never appear at o_parallel.
REQ-036 Reset mid-group. Stimulus: drive rst=0 between clock edges after 2 words. Required: outputs clear immediately, with no clock edge needed; after release, words 8,9,10,11 produce exactly one write of {8,9,10,11}.
REQ-037 Clock enable. Stimulus: ce=0 for 5 cycles mid-group, with i_valid=1. Required: no acceptance, fifo_we=0, state frozen; the group completes correctly after ce returns to 1.
